// File: rtl/wots_base_w_digits.sv
// Streams a digest as WOTS base-w digits followed by checksum digits.
// Ports: clk, reset (sync, active-high), start, msg_in, digit_ready ->
//   digit_valid, digit, chain_idx, busy, done.
//   Optional (WOTS_BASE_W_STEP_OUT_EN): mode in, start_step/end_step out.
module wots_base_w_digits #(
  parameter int WOTS_W     = 16,
  parameter int WOTS_LOG_W = $clog2(WOTS_W),
  parameter int MSG_LEN    = 256,
  parameter int WOTS_LEN1  = MSG_LEN / WOTS_LOG_W,
  parameter int WOTS_LEN2  = 3,
  parameter int CSUM_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MSG_LEN-1:0]    msg_in,
  input  logic                  digit_ready,
`ifdef WOTS_BASE_W_STEP_OUT_EN
  input  logic [1:0]            mode,
  output logic [WOTS_LOG_W-1:0] start_step,
  output logic [WOTS_LOG_W-1:0] end_step,
`endif
  output logic                  digit_valid,
  output logic [WOTS_LOG_W-1:0] digit,
  output logic [6:0]            chain_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int WOTS_LEN = WOTS_LEN1 + WOTS_LEN2;
  localparam int ACC_W    = $clog2(WOTS_LEN1 * (WOTS_W - 1) + 1);
  // Left-align the checksum digits to a byte boundary.
  localparam int SH       = 8 - ((WOTS_LEN2 * WOTS_LOG_W) % 8);
  localparam logic [WOTS_LOG_W-1:0] DMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_MSG,
    EMIT_CSUM,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [MSG_LEN-1:0]    msg_reg;
  logic [ACC_W-1:0]      csum;
  logic [ACC_W-1:0]      csum_nx;
  logic [CSUM_W-1:0]     csum_sh;
  logic [CSUM_W-1:0]     csum_fit;
  logic [CSUM_W-1:0]     csum_sh_nx;
  logic [6:0]            idx;
  logic [WOTS_LOG_W-1:0] cur;
  logic [WOTS_LOG_W-1:0] cur_inv;
  logic                  hs;
  logic                  last_msg;
  logic                  last_csum;

  // Message and checksum both shift left, so the live digit is the MSBs.
  assign cur = (state == EMIT_CSUM) ? csum_sh[CSUM_W-1 -: WOTS_LOG_W]
                                    : msg_reg[MSG_LEN-1 -: WOTS_LOG_W];

  // w is a power of two, so w-1-d is the bitwise inverse of d.
  assign cur_inv    = ~cur;
  assign csum_nx    = csum + ACC_W'(cur_inv);
  assign csum_fit   = CSUM_W'(csum_nx);
  assign csum_sh_nx = csum_fit << SH;

  assign hs        = digit_valid & digit_ready;
  assign last_msg  = (idx == 7'(WOTS_LEN1 - 1));
  assign last_csum = (idx == 7'(WOTS_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    digit_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = EMIT_MSG;
      end
      EMIT_MSG: begin
        digit_valid = 1'b1;
        busy        = 1'b1;
        if (hs && last_msg) state_nx = EMIT_CSUM;
      end
      EMIT_CSUM: begin
        digit_valid = 1'b1;
        busy        = 1'b1;
        if (hs && last_csum) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign digit     = digit_valid ? cur : '0;
  assign chain_idx = digit_valid ? idx : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_reg <= '0;
      csum    <= '0;
      csum_sh <= '0;
      idx     <= '0;
    end else if (state == IDLE && start) begin
      msg_reg <= msg_in;
      csum    <= '0;
      csum_sh <= '0;
      idx     <= '0;
    end else if (hs) begin
      idx <= idx + 7'd1;
      if (state == EMIT_MSG) begin
        msg_reg <= msg_reg << WOTS_LOG_W;
        csum    <= csum_nx;
        if (last_msg) csum_sh <= csum_sh_nx;
      end else begin
        csum_sh <= csum_sh << WOTS_LOG_W;
      end
    end
  end

`ifdef WOTS_BASE_W_STEP_OUT_EN
  logic [1:0] mode_reg;

  always_ff @(posedge clk) begin
    if (reset)                      mode_reg <= '0;
    else if (state == IDLE && start) mode_reg <= mode;
  end

  always_comb begin
    start_step = '0;
    end_step   = '0;
    if (digit_valid) begin
      unique case (mode_reg)
        2'd1: end_step = digit;
        2'd2: begin
          start_step = digit;
          end_step   = DMAX;
        end
        default: end_step = DMAX;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_wots_base_w_digits.sv
// Self-checking bench for wots_base_w_digits.
// Table vectors, randomized streams vs. an arithmetic model, reset/start corners.
module tb_wots_base_w_digits;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [255:0] msg_in = '0;
  logic         digit_ready = 1'b0;
  logic         digit_valid;
  logic [3:0]   digit;
  logic [6:0]   chain_idx;
  logic         busy;
  logic         done;
`ifdef WOTS_BASE_W_STEP_OUT_EN
  logic [1:0]   mode = 2'd0;
  logic [3:0]   start_step;
  logic [3:0]   end_step;
`endif

  wots_base_w_digits dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .msg_in      (msg_in),
    .digit_ready (digit_ready),
`ifdef WOTS_BASE_W_STEP_OUT_EN
    .mode        (mode),
    .start_step  (start_step),
    .end_step    (end_step),
`endif
    .digit_valid (digit_valid),
    .digit       (digit),
    .chain_idx   (chain_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] exp_d [67];

  typedef struct {
    logic [255:0] msg;
    int           stall_at;
    int           stall_len;
    int           poke_at;
    logic [1:0]   md;
    logic [11:0]  exp_cs;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Digits straight from the definition: nibbles MSB-first, then
  // checksum = sum(15-d), shifted left by 4 in 16 bits, MSB-first.
  task automatic build_model(input logic [255:0] m);
    logic [255:0] t;
    int cs;
    int sh;
    cs = 0;
    for (int i = 0; i < 64; i++) begin
      t = m >> (252 - 4 * i);
      exp_d[i] = t[3:0];
      cs += 15 - int'(t[3:0]);
    end
    sh = (cs * 16) % 65536;
    for (int k = 0; k < 3; k++)
      exp_d[64 + k] = 4'((sh >> (12 - 4 * k)) & 15);
  endtask

  task automatic run_stream(input logic [255:0] m, input int stall_at,
                            input int stall_len, input int poke_at,
                            input bit rnd, input logic [1:0] md,
                            output logic [11:0] cs);
    int idx;
    int cyc;
    int stalled;
    bit poked;
    logic [3:0] es;
    logic [3:0] ee;
    cs = '0;
    idx = 0;
    cyc = 0;
    stalled = 0;
    poked = 0;
    build_model(m);
    msg_in = m;
    start = 1'b1;
    digit_ready = 1'b0;
`ifdef WOTS_BASE_W_STEP_OUT_EN
    mode = md;
`endif
    step();
    start = 1'b0;
    for (int j = 0; j < 8; j++) msg_in[j*32 +: 32] = $urandom();
`ifdef WOTS_BASE_W_STEP_OUT_EN
    mode = 2'($urandom_range(0, 3));
`endif
    while (idx < 67 && cyc < 3000) begin
      start = 1'b0;
      if (idx == poke_at && !poked) begin
        start = 1'b1;
        msg_in = ~m;
        poked = 1;
      end
      if (idx == stall_at && stalled < stall_len) begin
        digit_ready = 1'b0;
        stalled++;
      end else begin
        digit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      chk("stream", {digit_valid, busy, done, chain_idx, digit},
          {1'b1, 1'b1, 1'b0, 7'(idx), exp_d[idx]});
      es = 4'd0;
      ee = 4'd15;
      if (md == 2'd1) ee = exp_d[idx];
      if (md == 2'd2) es = exp_d[idx];
`ifdef WOTS_BASE_W_STEP_OUT_EN
      chk("steps", {start_step, end_step}, {es, ee});
`endif
      if (digit_ready) begin
        if (idx >= 64) cs = {cs[7:0], digit};
        idx++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk("stream_len", 64'(idx), 64'd67);
    if (!rnd) chk("cycles", 64'(cyc), 64'(67 + stall_len));
    digit_ready = 1'b0;
    start = 1'b1;
    chk("done_pulse", {done, digit_valid, busy}, 3'b100);
    step();
    start = 1'b0;
    chk("done_clear", {done, digit_valid, busy}, 3'b000);
    step();
    chk("idle_after", {done, digit_valid, busy}, 3'b000);
  endtask

  initial begin
    logic [255:0] m;
    logic [11:0]  cs;

    vecs[0] = '{256'd0, -1, 0, -1, 2'd2, 12'h3C0};
    vecs[1] = '{{256{1'b1}}, -1, 0, -1, 2'd1, 12'h000};
    vecs[2] = '{{4{64'h0123456789ABCDEF}}, -1, 0, -1, 2'd0, 12'h1E0};
    vecs[3] = '{{4{64'h0123456789ABCDEF}}, 10, 5, -1, 2'd3, 12'h1E0};
    vecs[4] = '{256'd0, -1, 0, 5, 2'd2, 12'h3C0};

    repeat (3) step();
    chk("reset_outs", {digit_valid, digit, chain_idx, busy, done}, '0);
`ifdef WOTS_BASE_W_STEP_OUT_EN
    chk("reset_steps", {start_step, end_step}, '0);
`endif
    reset = 1'b0;
    step();
    chk("idle", {digit_valid, busy, done}, 3'b000);

    for (int v = 0; v < 5; v++) begin
      run_stream(vecs[v].msg, vecs[v].stall_at, vecs[v].stall_len,
                 vecs[v].poke_at, 1'b0, vecs[v].md, cs);
      chk("csum_digits", 64'(cs), 64'(vecs[v].exp_cs));
    end

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 8; j++) m[j*32 +: 32] = $urandom();
      run_stream(m, -1, 0, -1, 1'b1, 2'($urandom_range(0, 3)), cs);
    end

    for (int j = 0; j < 8; j++) m[j*32 +: 32] = $urandom();
    msg_in = m;
    start = 1'b1;
    digit_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    chk("pre_reset_idx", 64'(chain_idx), 64'd30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    digit_ready = 1'b0;
    chk("reset_mid", {digit_valid, digit, chain_idx, busy, done}, '0);
`ifdef WOTS_BASE_W_STEP_OUT_EN
    chk("reset_mid_steps", {start_step, end_step}, '0);
`endif
    step();
    chk("reset_idle", {digit_valid, busy, done}, 3'b000);
    run_stream(256'd0, -1, 0, -1, 1'b0, 2'd2, cs);
    chk("csum_after_reset", 64'(cs), 64'h3C0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
